// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : scan_sequencer
// Brief   : Steps the En / w[1:0] controls of a 2-to-4 decoder through enabled
//           mask slots with per-slot dwell and blanking.
// Revision: 1.0  initial release
// ============================================================================
module scan_sequencer #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] mask,
    output logic       En,
    output logic [1:0] w,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_oneshot;

    logic [1:0] w_nxt;
    logic [1:0] w_first;
    logic       w_wrap;
    logic       w_adv_go;

    // Next set mask bit after i with mod-4 wrap; i itself is the last candidate.
    function automatic logic [1:0] nxt_slot(input logic [1:0] i, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = i;
        for (int k = 4; k >= 1; k--) begin
            c = i + 2'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    assign w_nxt    = nxt_slot(w, mask);
    assign w_first  = nxt_slot(2'd3, mask);
    assign w_wrap   = (w_nxt <= w);
    // Continue scanning only for a live, non-one-shot run with something to visit.
    assign w_adv_go = run && !r_oneshot && (mask != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_oneshot  <= 1'b0;
            En         <= 1'b0;
            w          <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    En    <= 1'b0;
                    r_cnt <= '0;
                    if (mask != 4'd0 && run) begin
                        r_state   <= S_DWELL;
                        En        <= 1'b1;
                        w         <= w_first;
                        r_oneshot <= 1'b0;
                    end else if (mask != 4'd0 && step) begin
                        r_state   <= S_DWELL;
                        En        <= 1'b1;
                        w         <= w_nxt;
                        r_oneshot <= 1'b1;
                    end
                end
                S_DWELL: begin
                    if (!run && !r_oneshot) begin
                        r_state <= S_IDLE;
                        En      <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DWELL_LAST) begin
                        r_cnt <= '0;
                        if (BLANK == 0) begin
                            r_state    <= w_adv_go ? S_DWELL : S_IDLE;
                            En         <= w_adv_go;
                            r_oneshot  <= 1'b0;
                            frame_done <= w_adv_go && w_wrap;
                            if (w_adv_go) w <= w_nxt;
                        end else begin
                            r_state <= S_BLANK;
                            En      <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        r_cnt      <= '0;
                        r_state    <= w_adv_go ? S_DWELL : S_IDLE;
                        En         <= w_adv_go;
                        r_oneshot  <= 1'b0;
                        frame_done <= w_adv_go && w_wrap;
                        if (w_adv_go) w <= w_nxt;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    En      <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_scan_sequencer
// Brief   : Checks two scan_sequencer builds (BLANK=2 and BLANK=0) against a
//           slot-timeline reference model under directed and random stimulus.
// Revision: 1.0  initial release
// ============================================================================
module tb_scan_sequencer;

    localparam int c_DWELL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] mask = 4'd0;
    logic       en0, en1, fd0, fd1;
    logic [1:0] w0, w1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per build: index 0 has BLANK=2, index 1 has BLANK=0.
    int         m_blank [2] = '{2, 0};
    logic       m_act   [2];
    int         m_pos   [2];
    logic [1:0] m_w     [2];
    logic       m_one   [2];
    logic       m_fd    [2];

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL(c_DWELL), .BLANK(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .run(run), .step(step), .mask(mask),
        .En(en0), .w(w0), .frame_done(fd0)
    );

    scan_sequencer #(.DWELL(c_DWELL), .BLANK(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .run(run), .step(step), .mask(mask),
        .En(en1), .w(w1), .frame_done(fd1)
    );

    function automatic logic [1:0] ref_next(input logic [1:0] cur, input logic [3:0] m);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(cur) + k) % 4;
            if (m[idx]) return 2'(idx);
        end
        return cur;
    endfunction

    function automatic logic [1:0] ref_lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Expected {En, w, frame_done}; En is high for the first DWELL clocks of a slot.
    function automatic logic [3:0] exp_vec(input int d);
        return {m_act[d] && (m_pos[d] < c_DWELL), m_w[d], m_fd[d]};
    endfunction

    task automatic model_step();
        logic [1:0] nw;
        for (int d = 0; d < 2; d++) begin
            m_fd[d] = 1'b0;
            if (rst) begin
                m_act[d] = 1'b0; m_pos[d] = 0; m_w[d] = 2'd0; m_one[d] = 1'b0;
            end else if (!m_act[d]) begin
                if (mask != 4'd0 && run) begin
                    m_act[d] = 1'b1; m_pos[d] = 0; m_w[d] = ref_lowest(mask); m_one[d] = 1'b0;
                end else if (mask != 4'd0 && step) begin
                    m_act[d] = 1'b1; m_pos[d] = 0; m_w[d] = ref_next(m_w[d], mask); m_one[d] = 1'b1;
                end
            end else if (m_pos[d] < c_DWELL && !run && !m_one[d]) begin
                m_act[d] = 1'b0;
            end else if (m_pos[d] == c_DWELL + m_blank[d] - 1) begin
                if (m_one[d] || mask == 4'd0 || !run) begin
                    m_act[d] = 1'b0; m_one[d] = 1'b0;
                end else begin
                    nw = ref_next(m_w[d], mask);
                    m_fd[d] = (nw <= m_w[d]);
                    m_w[d] = nw;
                    m_pos[d] = 0;
                end
            end else begin
                m_pos[d] = m_pos[d] + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; mask = 4'd0;
        tick(); tick();
        checks++;
        if ({en0, w0, fd0} !== 4'b0000) begin
            errors++; $display("FAIL reset_dut0 actual=%b required=0000", {en0, w0, fd0});
        end
        checks++;
        if ({en1, w1, fd1} !== 4'b0000) begin
            errors++; $display("FAIL reset_dut1 actual=%b required=0000", {en1, w1, fd1});
        end
        rst = 1'b0;
    endtask

    task automatic test_full_scan();
        int pulses = 0;
        mask = 4'hF; run = 1'b1;
        tick();
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (fd0) pulses++;
            checks++;
            if ({en0, w0, fd0} !== exp_vec(0)) begin
                errors++; $display("FAIL full_scan_dut0 cyc %0d actual=%b required=%b", cyc, {en0, w0, fd0}, exp_vec(0));
            end
            checks++;
            if ({en1, w1, fd1} !== exp_vec(1)) begin
                errors++; $display("FAIL full_scan_dut1 cyc %0d actual=%b required=%b", cyc, {en1, w1, fd1}, exp_vec(1));
            end
            if (k == 24) begin
                checks++;
                if ({en0, w0, fd0} !== 4'b1001) begin
                    errors++; $display("FAIL wrap_clock24 actual=%b required=1001", {en0, w0, fd0});
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL frame_pulses actual=%0d required=1", pulses);
        end
        run = 1'b0;
    endtask

    // Generic directed segment: hold current inputs for n clocks, checking both builds.
    task automatic test_segment(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            step = 1'b0;
            checks++;
            if ({en0, w0, fd0} !== exp_vec(0)) begin
                errors++; $display("FAIL %s_dut0 cyc %0d actual=%b required=%b", name, cyc, {en0, w0, fd0}, exp_vec(0));
            end
            checks++;
            if ({en1, w1, fd1} !== exp_vec(1)) begin
                errors++; $display("FAIL %s_dut1 cyc %0d actual=%b required=%b", name, cyc, {en1, w1, fd1}, exp_vec(1));
            end
        end
    endtask

    task automatic test_mask_1010();
        mask = 4'b1010; run = 1'b1;
        test_segment("mask1010", 30);
        run = 1'b0;
        test_segment("mask1010_stop", 8);
    endtask

    task automatic test_run_drop();
        mask = 4'hF; run = 1'b1;
        test_segment("run_drop_pre", 3);
        run = 1'b0;
        tick();
        checks++;
        if ({en0, fd0} !== 2'b00 || w0 !== m_w[0]) begin
            errors++; $display("FAIL run_drop_idle actual=%b required=0%b0", {en0, w0, fd0}, m_w[0]);
        end
        test_segment("run_drop_post", 6);
    endtask

    task automatic test_step();
        run = 1'b0; mask = 4'hF;
        step = 1'b1;
        test_segment("step_one", 9);
        step = 1'b1;
        test_segment("step_two", 9);
        run = 1'b1; step = 1'b1;
        test_segment("run_and_step", 14);
        run = 1'b0;
        test_segment("step_stop", 8);
    endtask

    task automatic test_single_slot();
        mask = 4'b0100; run = 1'b1;
        test_segment("single_slot", 20);
        run = 1'b0;
        test_segment("single_stop", 8);
    endtask

    task automatic test_mask_zero();
        mask = 4'hF; run = 1'b1;
        test_segment("mask_zero_pre", 2);
        mask = 4'd0;
        test_segment("mask_zero_post", 10);
        run = 1'b0;
    endtask

    task automatic test_rst_blank();
        mask = 4'hF; run = 1'b1;
        test_segment("rst_blank_pre", 5);
        rst = 1'b1;
        tick();
        checks++;
        if ({en0, w0, fd0} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_blank actual=%b required=0000", {en0, w0, fd0});
        end
        rst = 1'b0; run = 1'b0;
        test_segment("rst_blank_post", 4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            step = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) mask = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 599) == 0);
            tick();
            checks++;
            if ({en0, w0, fd0} !== exp_vec(0)) begin
                errors++; $display("FAIL random_dut0 cyc %0d actual=%b required=%b", cyc, {en0, w0, fd0}, exp_vec(0));
            end
            checks++;
            if ({en1, w1, fd1} !== exp_vec(1)) begin
                errors++; $display("FAIL random_dut1 cyc %0d actual=%b required=%b", cyc, {en1, w1, fd1}, exp_vec(1));
            end
        end
        rst = 1'b0; step = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_pos[d] = 0; m_w[d] = 2'd0; m_one[d] = 1'b0; m_fd[d] = 1'b0;
        end
        test_reset();
        test_full_scan();
        test_segment("settle", 4);
        test_mask_1010();
        test_run_drop();
        test_step();
        test_single_slot();
        test_mask_zero();
        test_rst_blank();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
